// File: rtl/osc_meas_pkg.sv
// Shared types and constants for the oscillator frequency counter.
package osc_meas_pkg;
  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  localparam logic [1:0] BYTE_LO   = 2'd0;
  localparam logic [1:0] BYTE_HI   = 2'd1;
  localparam logic [1:0] BYTE_STAT = 2'd2;
  localparam logic [1:0] BYTE_RSVD = 2'd3;

  localparam int STAT_VALID = 7;
  localparam int STAT_OVF   = 6;
  localparam int STAT_BUSY  = 5;
endpackage

// File: rtl/osc_edge_sync.sv
// Brings the free-running oscillator into the clk domain and flags its rising edges.
module osc_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_p
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_p = sync_q[SYNC_STAGES-1] & ~hist;
endmodule

// File: rtl/osc_freq_counter.sv
// Counts oscillator rising edges over a fixed gate window of clk cycles and
// exposes the latched count and status a byte at a time.
module osc_freq_counter
  import osc_meas_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int GATE_CYCLES = 10000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       osc_in,
  input  logic       start,
  input  logic       cont,
  input  logic [1:0] byte_sel,
  output logic [7:0] data_out,
  output logic       done,
  output logic       busy
);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t              state;
  logic [GATE_W-1:0]   gate_cnt;
  logic [CNT_W-1:0]    edge_cnt;
  logic [CNT_W-1:0]    result;
  logic                ovf_work;
  logic                ovf;
  logic                valid;
  logic                edge_p;
  logic [7:0]          stat;

  osc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (osc_in),
    .edge_p   (edge_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_work <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!ena) begin
        // Disable aborts any window; the last latched result is kept.
        state    <= IDLE;
        gate_cnt <= '0;
        edge_cnt <= '0;
        ovf_work <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start || cont) begin
              state    <= GATE;
              gate_cnt <= '0;
              edge_cnt <= '0;
              ovf_work <= 1'b0;
            end
          end
          GATE: begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            if (edge_p) begin
              if (edge_cnt == CNT_MAX) ovf_work <= 1'b1;
              else                     edge_cnt <= edge_cnt + CNT_W'(1);
            end
            if (gate_cnt == GATE_LAST) state <= DONE;
          end
          DONE: begin
            // Edges arriving in this single cycle are intentionally dropped.
            result   <= edge_cnt;
            ovf      <= ovf_work;
            valid    <= 1'b1;
            done     <= 1'b1;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_work <= 1'b0;
            state    <= cont ? GATE : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    stat             = 8'h00;
    stat[STAT_VALID] = valid;
    stat[STAT_OVF]   = ovf;
    stat[STAT_BUSY]  = busy;
    case (byte_sel)
      BYTE_LO:   data_out = result[7:0];
      BYTE_HI:   data_out = 8'(result >> 8);
      BYTE_STAT: data_out = stat;
      default:   data_out = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_osc_freq_counter.sv
// Self-checking bench: table of periodic runs, random oscillator runs against an
// edge-window model, and hand-written boundary, continuous, reset and enable cases.
module tb_osc_freq_counter;
  localparam int GA  = 100;
  localparam int GB  = 2000;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, ena_a, start_a, cont_a, done_a, busy_a;
  logic       osc_a = 1'b0;
  logic [1:0] sel_a;
  logic [7:0] dout_a;
  logic       rst_b, ena_b, start_b, cont_b, done_b, busy_b;
  logic       osc_b = 1'b0;
  logic [1:0] sel_b;
  logic [7:0] dout_b;

  osc_freq_counter #(.CNT_W(16), .GATE_W(16), .GATE_CYCLES(GA), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_a), .ena(ena_a), .osc_in(osc_a), .start(start_a),
    .cont(cont_a), .byte_sel(sel_a), .data_out(dout_a), .done(done_a), .busy(busy_a));

  osc_freq_counter #(.CNT_W(9), .GATE_W(16), .GATE_CYCLES(GB), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_b), .ena(ena_b), .osc_in(osc_b), .start(start_b),
    .cont(cont_b), .byte_sel(sel_b), .data_out(dout_b), .done(done_b), .busy(busy_b));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rises_a[$];
  logic prev_a = 1'b0;

  // oscillator source: 0 manual level, 1 periodic, 2 random per cycle
  int   mode_a = 0, per_a = 10, ph_a = 0;
  int   mode_b = 0, per_b = 2,  ph_b = 0;
  logic man_a = 1'b0, man_b = 1'b0;

  typedef struct {
    int per;
    int gap;
    int exp_res;
  } vec_t;
  vec_t vt[6];

  // posedge index at which each oscillator high level is first sampled
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (osc_a && !prev_a) rises_a.push_back(cyc);
    prev_a = osc_a;
  end

  always begin
    @(negedge clk);
    #1;
    case (mode_a)
      0:       osc_a = man_a;
      1:       begin ph_a = (ph_a + 1) % per_a; osc_a = (ph_a < per_a / 2); end
      default: osc_a = 1'($urandom_range(0, 1));
    endcase
    case (mode_b)
      0:       osc_b = man_b;
      default: begin ph_b = (ph_b + 1) % per_b; osc_b = (ph_b < per_b / 2); end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {rsvd, stat, hi, lo}
  task automatic rd(input bit b, output logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      if (b) sel_b = 2'(i); else sel_a = 2'(i);
      #1;
      v[8*i +: 8] = b ? dout_b : dout_a;
    end
  endtask

  // Edges whose synchronized pulse lands inside the GATE cycles [s+1, s+g].
  function automatic int model_cnt(input int q[$], input int s, input int g);
    int n = 0;
    foreach (q[i]) if (q[i] + LAT >= s + 1 && q[i] + LAT <= s + g) n++;
    return n;
  endfunction

  task automatic meas_a(input int edge_at, output int s);
    int d = -1;
    start_a = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < GA + 20 && d < 0; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (edge_at >= 0 && cyc == s + edge_at) man_a = 1'b1;
      if (done_a) d = cyc;
    end
    chk("done_time_a", d, s + GA + 1);
    man_a = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int s, d, prev, nd;

    rst_a = 1'b0; ena_a = 1'b1; start_a = 1'b0; cont_a = 1'b0; sel_a = 2'd0;
    rst_b = 1'b0; ena_b = 1'b1; start_b = 1'b0; cont_b = 1'b0; sel_b = 2'd0;
    repeat (3) @(negedge clk);
    rd(0, v);
    chk("reset_bytes", v, 32'h0);
    chk("reset_done", done_a, 1'b0);
    chk("reset_busy", busy_a, 1'b0);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);

    vt = '{'{10, 0, 10}, '{20, 3, 5}, '{25, 7, 4}, '{50, 1, 2}, '{4, 5, 25}, '{100, 11, 1}};
    mode_a = 1;
    foreach (vt[i]) begin
      per_a = vt[i].per;
      ph_a  = int'($urandom_range(0, vt[i].per - 1));
      repeat (vt[i].gap + 3) @(negedge clk);
      meas_a(-1, s);
      rd(0, v);
      chk("vec_result", v[15:0], vt[i].exp_res);
      chk("vec_stat", v[31:16], 16'h0080);
      chk("vec_busy", busy_a, 1'b0);
    end

    mode_a = 2;
    repeat (6) begin
      repeat ($urandom_range(2, 20)) @(negedge clk);
      meas_a(-1, s);
      rd(0, v);
      chk("rand_result", v[15:0], model_cnt(rises_a, s, GA));
      chk("rand_stat", v[23:16], 8'h80);
    end

    // single edge whose pulse hits the last GATE cycle, then the DONE cycle
    mode_a = 0; man_a = 1'b0;
    for (int off = 0; off < 2; off++) begin
      repeat (5) @(negedge clk);
      meas_a(GA - 3 + off, s);
      rd(0, v);
      chk(off == 0 ? "edge_last_gate" : "edge_done_cycle", v[15:0], off == 0 ? 1 : 0);
    end

    // continuous mode
    mode_a = 1; per_a = 20; ph_a = 0;
    repeat (4) @(negedge clk);
    cont_a = 1'b1;
    s = cyc + 1;
    for (int p = 0; p < 4; p++) begin
      d = -1;
      for (int k = 0; k < GA + 20 && d < 0; k++) begin
        @(negedge clk);
        if (done_a) d = cyc;
      end
      chk("cont_done_time", d, s + (p + 1) * (GA + 1));
      rd(0, v);
      chk("cont_result", v[15:0], 5);
      if (p == 2) cont_a = 1'b0;
    end
    chk("cont_busy_after", busy_a, 1'b0);
    nd = 0;
    repeat (GA + 20) begin @(negedge clk); if (done_a) nd++; end
    chk("cont_stopped", nd, 0);

    // reset in the middle of a window
    per_a = 10;
    meas_a(-1, s);
    rd(0, v);
    chk("pre_rst_result", v[15:0], 10);
    meas_a(-1, s);
    start_a = 1'b1;
    s = cyc + 1;
    while (cyc < s + 51) begin @(negedge clk); start_a = 1'b0; end
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    chk("midrst_done", done_a, 1'b0);
    chk("midrst_busy", busy_a, 1'b0);
    rd(0, v);
    chk("midrst_bytes", v, 32'h0);
    nd = 0;
    repeat (GA + 20) begin @(negedge clk); if (done_a || busy_a) nd++; end
    chk("midrst_quiet", nd, 0);

    // enable dropped mid-window
    per_a = 14;
    repeat (3) @(negedge clk);
    meas_a(-1, s);
    rd(0, v);
    prev = int'(v[15:0]);
    chk("pre_ena_result", prev, model_cnt(rises_a, s, GA));
    start_a = 1'b1;
    repeat (40) begin @(negedge clk); start_a = 1'b0; end
    ena_a = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    chk("ena_busy", busy_a, 1'b0);
    chk("ena_done", done_a, 1'b0);
    rd(0, v);
    chk("ena_hold", v[23:0], {8'h80, 16'(prev)});
    nd = 0;
    repeat (5) begin @(negedge clk); if (busy_a || done_a) nd++; end
    chk("ena_low_idle", nd, 0);
    ena_a = 1'b1;
    meas_a(-1, s);
    rd(0, v);
    chk("ena_restart", v[15:0], model_cnt(rises_a, s, GA));

    // saturation on the 9-bit instance: 1000 edges in 2000 cycles
    mode_b = 1; per_b = 2;
    repeat (4) @(negedge clk);
    start_b = 1'b1;
    s = cyc + 1;
    d = -1;
    for (int k = 0; k < GB + 20 && d < 0; k++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (done_b) d = cyc;
    end
    chk("sat_done_time", d, s + GB + 1);
    rd(1, v);
    chk("sat_lo", v[7:0], 8'hFF);
    chk("sat_hi", v[15:8], 8'h01);
    chk("sat_stat", v[23:16], 8'hC0);
    chk("sat_rsvd", v[31:24], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
